// File: rtl/imm_decode_stage_pkg.sv
// imm_pkg: opcodes, type one-hot indices, skid states and the decode result record.
package imm_pkg;
    localparam int OP_W = 7;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_IMM32  = 7'b0011011;
    localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_REG32  = 7'b0111011;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;
    localparam int T_J = 0;
    localparam int T_U = 1;
    localparam int T_B = 2;
    localparam int T_S = 3;
    localparam int T_I = 4;
    localparam int T_R = 5;
    localparam logic [5:0] K_J = 6'(1) << T_J;
    localparam logic [5:0] K_U = 6'(1) << T_U;
    localparam logic [5:0] K_B = 6'(1) << T_B;
    localparam logic [5:0] K_S = 6'(1) << T_S;
    localparam logic [5:0] K_I = 6'(1) << T_I;
    localparam logic [5:0] K_R = 6'(1) << T_R;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
    // imm is the 32-bit form; the stage sign-extends it to XLEN (zimm has bit 31 clear)
    typedef struct packed {
        logic [31:0] imm;
        logic [5:0]  kind;
        logic        illegal;
    } dec_t;
endpackage

// File: rtl/imm_decode_stage_comb.sv
// imm_decode_comb: classifies an RV instruction and builds its XLEN sign-extended immediate.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_LEN  = 7,
    parameter int EN_ZIMM = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      kind,
    output logic            illegal
);
    dec_t dec;
    logic [OP_LEN-1:0] op;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    assign op = instr[OP_LEN-1:0];
    always_comb begin
        i_imm = {{20{instr[31]}}, instr[31:20]};
        s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        u_imm = {instr[31:12], 12'b0};
        j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        dec = '{imm: '0, kind: '0, illegal: 1'b1};
        case (op)
            OP_JALR, OP_LOAD, OP_IMM: dec = '{imm: i_imm, kind: K_I, illegal: 1'b0};
            OP_IMM32:  if (XLEN == 64) dec = '{imm: i_imm, kind: K_I, illegal: 1'b0};
            OP_SYSTEM: if (EN_ZIMM != 0) dec = '{imm: instr[14] ? {27'b0, instr[19:15]} : i_imm, kind: K_I, illegal: 1'b0};
            OP_REG:    dec = '{imm: '0, kind: K_R, illegal: 1'b0};
            OP_REG32:  if (XLEN == 64) dec = '{imm: '0, kind: K_R, illegal: 1'b0};
            OP_STORE:  dec = '{imm: s_imm, kind: K_S, illegal: 1'b0};
            OP_BRANCH: dec = '{imm: b_imm, kind: K_B, illegal: 1'b0};
            OP_LUI, OP_AUIPC: dec = '{imm: u_imm, kind: K_U, illegal: 1'b0};
            OP_JAL:    dec = '{imm: j_imm, kind: K_J, illegal: 1'b0};
            default: ;
        endcase
    end
    assign imm = XLEN'(signed'(dec.imm));
    assign kind = dec.kind;
    assign illegal = dec.illegal;
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered, handshaked immediate decode with optional 2-entry skid buffer.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_LEN  = 7,
    parameter int TAG_W   = 32,
    parameter int SKID    = 1,
    parameter int EN_ZIMM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam int BW = XLEN + 7 + TAG_W;
    logic [XLEN-1:0] d_imm;
    logic [5:0] d_kind;
    logic d_illegal;
    logic [BW-1:0] in_beat, main_q, skid_q;
    skid_state_t state, nxt;
    logic rdy_q, accept, drain;
    imm_decode_comb #(.XLEN(XLEN), .OP_LEN(OP_LEN), .EN_ZIMM(EN_ZIMM)) u_dec (
        .instr(in_instr),
        .imm(d_imm),
        .kind(d_kind),
        .illegal(d_illegal)
    );
    assign in_beat = {d_imm, d_kind, d_illegal, in_tag};
    assign {out_imm, out_type, out_illegal, out_tag} = main_q;
    assign out_valid = state != EMPTY;
    // without a skid entry, readiness must look through to out_ready; rdy_q still gates it until the first edge after reset
    assign in_ready = rdy_q && !flush && (SKID != 0 || state == EMPTY || out_ready);
    assign accept = in_valid && in_ready;
    assign drain = out_valid && out_ready && !flush;
    always_comb begin
        nxt = state;
        case (state)
            EMPTY:   nxt = accept ? ONE : EMPTY;
            ONE:     nxt = (accept && !drain) ? TWO : (drain && !accept) ? EMPTY : ONE;
            TWO:     nxt = drain ? ONE : TWO;
            default: nxt = EMPTY;
        endcase
        if (flush) nxt = EMPTY;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            rdy_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= nxt;
            rdy_q <= nxt != TWO;
            if (accept && (state == EMPTY || (state == ONE && drain))) main_q <= in_beat;
            else if (state == TWO && drain) main_q <= skid_q;
            if (accept && state == ONE && !drain) skid_q <= in_beat;
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed and random checks of XLEN=32 and XLEN=64 stages against a field-level model.
module tb_imm_decode_stage;
    logic clk, rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;
    logic in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_tag32;
    logic [5:0] out_type32;
    logic in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [5:0] out_type64;
    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];
    bit live, acc, drn, cur_f;
    logic [31:0] cur_ins, cur_tag;
    logic [6:0] ops[14] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011,
                            7'b0111011, 7'b1110011, 7'b0000000, 7'b0110010};

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_type(out_type32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );
    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_type(out_type64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", name, obs, exp);
        end
    endtask

    // One-hot order {R,I,S,B,U,J}; immediates built from fields with signed arithmetic
    function automatic void ref_dec(input logic [31:0] i, input bit x64, output logic [63:0] imm, output logic [5:0] t);
        longint s;
        s = longint'($signed(i));
        t = 6'b0;
        case (i[6:0])
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: t = 6'b010000;
            7'b0011011: t = x64 ? 6'b010000 : 6'b0;
            7'b0110011: t = 6'b100000;
            7'b0111011: t = x64 ? 6'b100000 : 6'b0;
            7'b0100011: t = 6'b001000;
            7'b1100011: t = 6'b000100;
            7'b0110111, 7'b0010111: t = 6'b000010;
            7'b1101111: t = 6'b000001;
            default: t = 6'b0;
        endcase
        imm = 64'd0;
        if (t == 6'b010000) imm = (i[6:0] == 7'b1110011 && i[14]) ? 64'(i[19:15]) : 64'(s >>> 20);
        if (t == 6'b001000) imm = 64'(((s >>> 25) << 5) | longint'(i[11:7]));
        if (t == 6'b000100) imm = 64'(((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1));
        if (t == 6'b000010) imm = 64'(longint'($signed(i & 32'hFFFFF000)));
        if (t == 6'b000001) imm = 64'(((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1));
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tg, input logic r, input logic f);
        logic [63:0] e, h;
        logic [5:0] t;
        bit exp_rdy;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_tag = tg; out_ready = r; flush = f;
        #1;
        exp_rdy = live && !f && q.size() < 2;
        chk("in_ready32", in_ready32, exp_rdy);
        chk("in_ready64", in_ready64, exp_rdy);
        chk("out_valid32", out_valid32, q.size() != 0);
        chk("out_valid64", out_valid64, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            ref_dec(h[63:32], 1'b0, e, t);
            chk("imm32", out_imm32, e[31:0]);
            chk("type32", out_type32, t);
            chk("illegal32", out_illegal32, t == 6'b0);
            chk("tag32", out_tag32, h[31:0]);
            ref_dec(h[63:32], 1'b1, e, t);
            chk("imm64", out_imm64, e);
            chk("type64", out_type64, t);
            chk("illegal64", out_illegal64, t == 6'b0);
            chk("tag64", out_tag64, h[31:0]);
        end
        acc = v && exp_rdy;
        drn = r && !f && q.size() != 0;
        cur_f = f; cur_ins = ins; cur_tag = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        if (cur_f) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({cur_ins, cur_tag});
        end
        live = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_tag = 0;
        live = 0; acc = 0; drn = 0; cur_f = 0; cur_ins = 0; cur_tag = 0;
        #12;
        chk("rst_valid", out_valid32, 1'b0);
        chk("rst_imm", out_imm64, 64'd0);
        chk("rst_type", out_type32, 6'd0);
        chk("rst_illegal", out_illegal32, 1'b0);
        chk("rst_tag", out_tag32, 32'd0);
        chk("rst_ready", in_ready32, 1'b0);
        @(posedge clk); #1 rst = 0;
        drive(0, 0, 0, 1, 0); tick();
        drive(1, 32'hFFF00093, 32'd10, 1, 0); tick();
        drive(0, 0, 0, 1, 0);
        chk("t1_valid", out_valid32, 1'b1);
        chk("t1_imm", out_imm32, 32'hFFFFFFFF);
        chk("t1_type", out_type32, 6'b010000);
        tick();
        drive(1, 32'h800000B7, 32'd11, 1, 0); tick();
        drive(0, 0, 0, 1, 0);
        chk("t2_imm", out_imm64, 64'hFFFFFFFF80000000);
        chk("t2_type", out_type64, 6'b000010);
        tick();
        drive(1, 32'hFE000EE3, 32'd12, 1, 0); tick();
        drive(1, 32'h00000000, 32'd13, 1, 0);
        chk("t3_imm", out_imm32, 32'hFFFFFFFC);
        chk("t3_type", out_type32, 6'b000100);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("t3_illegal", out_illegal32, 1'b1);
        chk("t3_ill_type", out_type32, 6'd0);
        chk("t3_ill_imm", out_imm64, 64'd0);
        tick();
        drive(1, 32'h00A00093, 32'd1, 0, 0); tick();
        drive(1, 32'h00B00093, 32'd2, 0, 0); tick();
        drive(1, 32'h00C00093, 32'd3, 0, 0);
        chk("t4_full", in_ready32, 1'b0);
        tick();
        drive(1, 32'h00C00093, 32'd3, 1, 0);
        chk("t4_first", out_tag32, 32'd1);
        tick();
        drive(1, 32'h00C00093, 32'd3, 1, 0);
        chk("t4_second", out_tag32, 32'd2);
        chk("t4_ready", in_ready32, 1'b1);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("t4_third", out_tag32, 32'd3);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("t4_empty", out_valid32, 1'b0);
        tick();
        drive(1, 32'h00100093, 32'd4, 0, 0); tick();
        drive(1, 32'h00200093, 32'd5, 0, 0); tick();
        drive(1, 32'h00300093, 32'd6, 1, 1);
        chk("t5_flush_ready", in_ready32, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("t5_valid", out_valid32, 1'b0);
        chk("t5_ready", in_ready32, 1'b1);
        tick();
        drive(1, 32'h00700093, 32'd7, 0, 0); tick();
        #2 rst = 1;
        #1;
        chk("t6_async_valid", out_valid32, 1'b0);
        chk("t6_async_tag", out_tag64, 32'd0);
        q.delete(); live = 0;
        @(posedge clk); #1 rst = 0;
        drive(1, 32'h00800093, 32'd8, 1, 0); tick();
        drive(1, 32'h00800093, 32'd8, 1, 0); tick();
        drive(0, 0, 0, 1, 0);
        chk("t6_latency", out_valid32, 1'b1);
        chk("t6_tag", out_tag32, 32'd8);
        tick();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom();
            drive($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 13)]}, $urandom(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
